// File: rtl/memory_access.sv
// MIPS memory stage: LW/SW data-bus access FSM, registered writeback record and M-stage forwarding port.
// Define MEM_ALIGN_TRAP_EN to turn misaligned LW/SW into AdEL/AdES exceptions instead of bus accesses.
module memory_access #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_opcode,
  input  logic [4:0]        in_dstE,
  input  logic [4:0]        in_dstM,
  input  logic [31:0]       in_valE,
  input  logic [31:0]       in_valA,
  input  logic [31:0]       in_pc,
  output logic              dreq_valid,
  input  logic              dreq_ready,
  output logic [ADDR_W-1:0] dreq_addr,
  output logic [3:0]        dreq_strobe,
  output logic [31:0]       dreq_wdata,
  input  logic              dresp_valid,
  input  logic [31:0]       dresp_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic [4:0]        out_dst,
  output logic [31:0]       out_val,
  output logic              out_wen,
  output logic [1:0]        out_exc,
  output logic [4:0]        fwd_dst,
  output logic [31:0]       fwd_val,
  output logic              fwd_ready
);
  localparam logic [5:0] OP_LW = 6'h23;
  localparam logic [5:0] OP_SW = 6'h2b;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t            state_q;
  logic              dreq_valid_q, out_valid_q, wen_q, fwd_ready_q, is_lw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        strobe_q;
  logic [31:0]       wdata_q, pc_q, val_q;
  logic [4:0]        dst_q;

  logic accept, in_is_lw, in_is_sw, in_trap;

  assign in_is_lw = (in_opcode == OP_LW);
  assign in_is_sw = (in_opcode == OP_SW);
  assign in_ready = !reset && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
  assign accept   = in_valid && in_ready;

`ifdef MEM_ALIGN_TRAP_EN
  logic [1:0] exc_q;
  assign in_trap = (in_is_lw || in_is_sw) && (in_valE[1:0] != 2'b00);
  assign out_exc = exc_q;
`else
  assign in_trap = 1'b0;
  assign out_exc = 2'b00;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      dreq_valid_q <= 1'b0;
      out_valid_q  <= 1'b0;
      wen_q        <= 1'b0;
      fwd_ready_q  <= 1'b0;
      is_lw_q      <= 1'b0;
      addr_q       <= '0;
      strobe_q     <= 4'h0;
      wdata_q      <= 32'h0;
      pc_q         <= 32'h0;
      val_q        <= 32'h0;
      dst_q        <= 5'd0;
`ifdef MEM_ALIGN_TRAP_EN
      exc_q        <= 2'b00;
`endif
    end else if (accept) begin
      pc_q    <= in_pc;
      is_lw_q <= in_is_lw && !in_trap;
`ifdef MEM_ALIGN_TRAP_EN
      exc_q   <= !in_trap ? 2'b00 : (in_is_sw ? 2'b10 : 2'b01);
`endif
      if (in_trap) begin
        state_q      <= DONE;
        dreq_valid_q <= 1'b0;
        out_valid_q  <= 1'b1;
        dst_q        <= 5'd0;
        val_q        <= in_valE;
        wen_q        <= 1'b0;
        fwd_ready_q  <= 1'b1;
      end else if (in_is_lw || in_is_sw) begin
        state_q      <= REQ;
        dreq_valid_q <= 1'b1;
        out_valid_q  <= 1'b0;
        addr_q       <= ADDR_W'({in_valE[31:2], 2'b00});
        strobe_q     <= in_is_sw ? 4'hF : 4'h0;
        wdata_q      <= in_is_sw ? in_valA : 32'h0;
        dst_q        <= in_is_lw ? in_dstM : 5'd0;
        val_q        <= 32'h0;
        wen_q        <= 1'b0;
        fwd_ready_q  <= !in_is_lw;
      end else begin
        state_q      <= DONE;
        dreq_valid_q <= 1'b0;
        out_valid_q  <= 1'b1;
        dst_q        <= in_dstE;
        val_q        <= in_valE;
        wen_q        <= (in_dstE != 5'd0);
        fwd_ready_q  <= 1'b1;
      end
    end else begin
      case (state_q)
        REQ, WAIT: begin
          if ((state_q == REQ) && dreq_ready) begin
            dreq_valid_q <= 1'b0;
            state_q      <= WAIT;
          end
          // A response only counts once the address handshake has happened (now or earlier).
          if (((state_q == WAIT) || dreq_ready) && dresp_valid) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            fwd_ready_q <= 1'b1;
            wen_q       <= is_lw_q && (dst_q != 5'd0);
            if (is_lw_q) val_q <= dresp_data;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            dst_q       <= 5'd0;
            val_q       <= 32'h0;
            wen_q       <= 1'b0;
            fwd_ready_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dreq_valid  = dreq_valid_q;
  assign dreq_addr   = addr_q;
  assign dreq_strobe = strobe_q;
  assign dreq_wdata  = wdata_q;
  assign out_valid   = out_valid_q;
  assign out_pc      = pc_q;
  assign out_dst     = dst_q;
  assign out_val     = val_q;
  assign out_wen     = wen_q;
  assign fwd_dst     = dst_q;
  assign fwd_val     = val_q;
  assign fwd_ready   = fwd_ready_q;
endmodule

// File: tb/tb_memory_access.sv
// Directed plus randomized bench for memory_access against a transaction-level reference model.
module tb_memory_access;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_opcode;
  logic [4:0]  in_dstE, in_dstM;
  logic [31:0] in_valE, in_valA, in_pc;
  logic        dreq_valid, dreq_ready;
  logic [31:0] dreq_addr;
  logic [3:0]  dreq_strobe;
  logic [31:0] dreq_wdata;
  logic        dresp_valid;
  logic [31:0] dresp_data;
  logic        out_valid, out_ready;
  logic [31:0] out_pc;
  logic [4:0]  out_dst;
  logic [31:0] out_val;
  logic        out_wen;
  logic [1:0]  out_exc;
  logic [4:0]  fwd_dst;
  logic [31:0] fwd_val;
  logic        fwd_ready;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  memory_access #(.ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_dstE(in_dstE), .in_dstM(in_dstM), .in_valE(in_valE), .in_valA(in_valA), .in_pc(in_pc),
    .dreq_valid(dreq_valid), .dreq_ready(dreq_ready), .dreq_addr(dreq_addr),
    .dreq_strobe(dreq_strobe), .dreq_wdata(dreq_wdata),
    .dresp_valid(dresp_valid), .dresp_data(dresp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_dst(out_dst),
    .out_val(out_val), .out_wen(out_wen), .out_exc(out_exc),
    .fwd_dst(fwd_dst), .fwd_val(fwd_val), .fwd_ready(fwd_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full transaction: model expectations, bus responder with given delays, record check.
  task automatic run_txn(input logic [5:0] op, input logic [4:0] de, input logic [4:0] dm,
                         input logic [31:0] ve, input logic [31:0] va, input logic [31:0] pc,
                         input logic [31:0] rd, input int rdy_dly, input int rsp_dly);
    logic        lw, sw, mem, trap;
    logic [4:0]  exp_dst;
    logic [31:0] exp_val;
    logic [1:0]  exp_exc;
    lw  = (op == 6'h23);
    sw  = (op == 6'h2b);
    mem = lw || sw;
`ifdef MEM_ALIGN_TRAP_EN
    trap = mem && (ve % 4 != 0);
`else
    trap = 1'b0;
`endif
    exp_dst = trap ? 5'd0 : (lw ? dm : (sw ? 5'd0 : de));
    exp_val = lw ? rd : ve;
    exp_exc = trap ? (sw ? 2'b10 : 2'b01) : 2'b00;

    chk("in_ready_start", in_ready, 1);
    in_valid = 1'b1; in_opcode = op; in_dstE = de; in_dstM = dm;
    in_valE = ve; in_valA = va; in_pc = pc;
    @(negedge clk);
    in_valid = 1'b0;
    if (mem && !trap) begin
      chk("dreq_valid", dreq_valid, 1);
      chk("dreq_addr", dreq_addr, (ve / 4) * 4);
      chk("dreq_strobe", dreq_strobe, sw ? 4'hF : 4'h0);
      if (sw) chk("dreq_wdata", dreq_wdata, va);
      chk("fwd_dst_req", fwd_dst, exp_dst);
      chk("fwd_ready_req", fwd_ready, !lw);
      chk("out_valid_req", out_valid, 0);
      for (int i = 0; i < rdy_dly; i++) begin
        @(negedge clk);
        chk("dreq_hold_valid", dreq_valid, 1);
        chk("dreq_hold_addr", dreq_addr, (ve / 4) * 4);
      end
      dreq_ready = 1'b1;
      if (rsp_dly == 0) begin
        dresp_valid = 1'b1;
        dresp_data  = rd;
      end
      @(negedge clk);
      dreq_ready  = 1'b0;
      dresp_valid = 1'b0;
      if (rsp_dly > 0) begin
        chk("dreq_valid_wait", dreq_valid, 0);
        chk("out_valid_wait", out_valid, 0);
        for (int i = 0; i < rsp_dly - 1; i++) begin
          @(negedge clk);
          chk("out_valid_wait", out_valid, 0);
          chk("fwd_ready_wait", fwd_ready, !lw);
        end
        dresp_valid = 1'b1;
        dresp_data  = rd;
        @(negedge clk);
        dresp_valid = 1'b0;
      end
    end else begin
      chk("dreq_valid_none", dreq_valid, 0);
    end
    chk("out_valid", out_valid, 1);
    chk("out_dst", out_dst, exp_dst);
    chk("out_wen", out_wen, exp_dst != 5'd0);
    chk("out_pc", out_pc, pc);
    chk("out_exc", out_exc, exp_exc);
    chk("fwd_dst", fwd_dst, exp_dst);
    chk("fwd_ready", fwd_ready, 1);
    if (!sw && !trap) begin
      chk("out_val", out_val, exp_val);
      chk("fwd_val", fwd_val, exp_val);
    end
  endtask

  initial begin
    logic [5:0] op;
    logic [31:0] ve;
    reset = 1'b1; in_valid = 1'b0; in_opcode = 6'h0; in_dstE = 5'd0; in_dstM = 5'd0;
    in_valE = 32'h0; in_valA = 32'h0; in_pc = 32'h0;
    dreq_ready = 1'b0; dresp_valid = 1'b0; dresp_data = 32'h0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_dreq_valid", dreq_valid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_wen", out_wen, 0);
    chk("rst_out_exc", out_exc, 0);
    chk("rst_fwd_dst", fwd_dst, 0);
    chk("rst_fwd_val", fwd_val, 0);
    chk("rst_fwd_ready", fwd_ready, 0);
    reset = 1'b0;
    @(negedge clk);

    run_txn(6'h09, 5'd5, 5'd0, 32'h1234, 32'h0, 32'h400, 32'h0, 0, 0);
    run_txn(6'h23, 5'd0, 5'd8, 32'h100, 32'h0, 32'h404, 32'hCAFE, 2, 3);
    run_txn(6'h2b, 5'd0, 5'd0, 32'h204, 32'hBEEF, 32'h408, 32'h0, 0, 0);
    run_txn(6'h23, 5'd0, 5'd7, 32'h102, 32'h0, 32'h40C, 32'h5A5A, 1, 1);
    run_txn(6'h09, 5'd0, 5'd0, 32'h77, 32'h0, 32'h410, 32'h0, 0, 0);

    // Backpressure in DONE with the next instruction already waiting.
    run_txn(6'h09, 5'd3, 5'd0, 32'hAAAA, 32'h0, 32'h414, 32'h0, 0, 0);
    out_ready = 1'b0;
    in_valid = 1'b1; in_opcode = 6'h0c; in_dstE = 5'd9; in_valE = 32'hBBBB; in_pc = 32'h418;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_dst", out_dst, 3);
      chk("bp_out_val", out_val, 32'hAAAA);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_next_valid", out_valid, 1);
    chk("bp_next_dst", out_dst, 9);
    chk("bp_next_val", out_val, 32'hBBBB);
    chk("bp_next_pc", out_pc, 32'h418);

    // Reset while waiting for a response; the late response must be dropped.
    in_valid = 1'b1; in_opcode = 6'h23; in_dstM = 5'd4; in_valE = 32'h300; in_pc = 32'h41C;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rw_dreq_valid", dreq_valid, 1);
    dreq_ready = 1'b1;
    @(negedge clk);
    dreq_ready = 1'b0;
    reset = 1'b1;
    #1;
    chk("rw_out_valid", out_valid, 0);
    chk("rw_dreq_valid_rst", dreq_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    dresp_valid = 1'b1; dresp_data = 32'hDEAD;
    @(negedge clk);
    dresp_valid = 1'b0;
    chk("rw_late_out_valid", out_valid, 0);
    chk("rw_late_in_ready", in_ready, 1);
    @(negedge clk);
    chk("rw_late_out_valid2", out_valid, 0);

    // Reset during the request phase drops dreq_valid asynchronously.
    in_valid = 1'b1; in_opcode = 6'h2b; in_valE = 32'h500; in_valA = 32'h1; in_pc = 32'h420;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rr_dreq_valid", dreq_valid, 1);
    reset = 1'b1;
    #1;
    chk("rr_dreq_valid_rst", dreq_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 2))
        0: op = 6'h23;
        1: op = 6'h2b;
        default: begin
          op = 6'($urandom_range(0, 63));
          if (op == 6'h23 || op == 6'h2b) op = 6'h09;
        end
      endcase
      ve = $urandom;
      if ($urandom_range(0, 1) == 0) ve = (ve / 4) * 4;
      run_txn(op, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), ve, $urandom,
              $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
    end
    @(negedge clk);
    chk("drain_out_valid", out_valid, 0);
    chk("drain_fwd_dst", fwd_dst, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/memory_access.md
# memory_access

Memory stage of the five-stage MIPS pipeline. Accepts one execute-stage result at a time over a valid/ready handshake and performs the data-bus access for `LW`/`SW` through a small FSM. Presents a registered writeback record to the writeback stage; non-memory ops pass through with one cycle of latency. Also drives the M-stage forwarding port used by decode hazard logic.

## Interface
- `ADDR_W`, 32, data-bus address width; bits above 32 are zero-extended.
- `clk`  in  1  clock, rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  execute result valid.
- `in_ready`  out  1  stage can accept this cycle.
- `in_opcode`  in  6  instruction opcode; `LW`=6'h23, `SW`=6'h2b.
- `in_dstE`, `in_dstM`  in  5  ALU and load destination registers; 0 = none.
- `in_valE`  in  32  ALU result: effective address for `LW`/`SW`, otherwise result.
- `in_valA`  in  32  store data for `SW`.
- `in_pc`  in  32  instruction PC.
- `dreq_valid`  out  1  data request valid.
- `dreq_ready`  in  1  request accepted (address handshake).
- `dreq_addr`  out  ADDR_W  request address.
- `dreq_strobe`  out  4  byte write enables; 4'h0 = read.
- `dreq_wdata`  out  32  store data.
- `dresp_valid`  in  1  response valid (read data, or write done).
- `dresp_data`  in  32  read data.
- `out_valid`  out  1  writeback record valid.
- `out_ready`  in  1  writeback stage accepts.
- `out_pc`  out  32  PC of the record.
- `out_dst`  out  5  destination register.
- `out_val`  out  32  value to write.
- `out_wen`  out  1  register write; set only when `out_dst` != 0.
- `out_exc`  out  2  {AdES, AdEL}; present only with `MEM_ALIGN_TRAP_EN`, otherwise tied 0.
- `fwd_dst`  out  5  destination register of the instruction held in the stage; 0 when idle.
- `fwd_val`  out  32  value to forward.
- `fwd_ready`  out  1  `fwd_val` is final; low while a load is outstanding.

## Operation
- States: IDLE, REQ, WAIT, DONE. Reset: IDLE. All outputs are 0 in reset.
- Accept: `in_valid && in_ready`. `in_ready` = (IDLE) or (DONE && `out_ready`). Accepted fields are latched.
- Non-memory op, accepted: go to DONE. `out_dst`=`in_dstE`; `out_val`=`in_valE`.
- `LW`/`SW`, accepted: go to REQ.
  - `dreq_valid`=1. `dreq_addr`=`valE` with the low 2 bits cleared.
  - Strobe: 4'hF for `SW`, 4'h0 for `LW`.
  - `dreq_addr`, `dreq_strobe` and `dreq_wdata` stay stable until `dreq_ready`.
- REQ with `dreq_ready`: go to WAIT. If `dresp_valid` is also high in the same cycle, go directly to DONE.
- WAIT with `dresp_valid`: go to DONE. `LW` captures `dresp_data`, with `out_dst`=`dstM`. `SW` sets `out_dst`=0.
- DONE: `out_valid`=1. On `out_ready`:
  - If a new input is accepted in the same cycle, go to REQ or DONE for it.
  - Otherwise go to IDLE.
- `dresp_valid` in IDLE or REQ (before the address handshake) is ignored.
- Forwarding:
  - `fwd_dst` is the held instruction's destination in REQ, WAIT and DONE.
  - `fwd_ready`=1 for non-loads, and for a load once it is in DONE.

## Timing
- Non-memory op: accepted in cycle N, `out_valid` in N+1. Back-to-back throughput is 1 per cycle.
- Load/store:
  - `dreq_valid` in N+1.
  - `out_valid` in the cycle after the `dresp_valid` edge.
  - Minimum latency is 2 cycles (ready and response in the same cycle).
- Backpressure: `out_ready`=0 holds DONE and all `out_*` unchanged; `in_ready`=0.
- Reset during REQ or WAIT:
  - `dreq_valid` and `out_valid` drop immediately (asynchronous).
  - A late response after reset is ignored.

## Configuration
- `MEM_ALIGN_TRAP_EN` defined:
  - An `LW` with `valE[1:0]`!=0 skips the bus and goes straight to DONE with `out_exc`=2'b01, `out_wen`=0.
  - A misaligned `SW` does the same with `out_exc`=2'b10.
- Not defined: low address bits are silently cleared, the access proceeds, and `out_exc`=0.

## Test plan
- After reset, `in_valid` with opcode 6'h09, `dstE`=5, `valE`=32'h1234 -> next cycle `out_valid`=1, `out_dst`=5, `out_val`=32'h1234, `out_wen`=1.
- `LW` with `valE`=32'h100, `dstM`=8; `dreq_ready` after 2 cycles, `dresp_data`=32'hCAFE 3 cycles later:
  - `dreq_addr`=32'h100, strobe=0 while requesting.
  - `out_val`=32'hCAFE, `out_dst`=8.
  - `fwd_ready`=0 until DONE.
- `SW` with `valE`=32'h204, `valA`=32'hBEEF; `dreq_ready` and `dresp_valid` in the same cycle:
  - Strobe=4'hF, `wdata`=32'hBEEF.
  - `out_valid` the next cycle with `out_wen`=0.
- `out_ready`=0 for 3 cycles in DONE, with a new input pending:
  - `in_ready`=0 and outputs stable.
  - On `out_ready`=1 the new input is accepted in the same cycle.
- Assert `reset` in WAIT, then pulse `dresp_valid` after release -> `dreq_valid`=0 immediately, state IDLE, no `out_valid`.
- Misaligned `LW` at 32'h102:
  - With `MEM_ALIGN_TRAP_EN`: no `dreq_valid`, `out_exc`=2'b01.
  - Without it: `dreq_addr`=32'h100.
